// File: rtl/rv_reg_usage_decode_if.sv
// Stage-side bundle for the register-usage decoder: capture controls, instruction in,
// decoded source/destination usage out.
interface rv_reg_usage_decode_if;
    logic        en;
    logic        flush;
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        re1;
    logic        re2;
    logic [4:0]  ws;
    logic        we_bypass;
    logic        we_stall;

    modport master (
        output en, flush, inst,
        input  rs1, rs2, re1, re2, ws, we_bypass, we_stall
    );

    modport slave (
        input  en, flush, inst,
        output rs1, rs2, re1, re2, ws, we_bypass, we_stall
    );
endinterface

// File: rtl/rv_reg_usage_decode.sv
// RV32I register-usage decoder: captures one instruction per enabled edge and decodes
// rs1/rs2/ws usage for hazard logic. Optional macro RV_X0_FILTER_EN masks x0 references.
module rv_reg_usage_decode #(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rv_reg_usage_decode_if.slave   bus
);

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IALU   = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    logic [XLEN-1:0] inst_p1;
    logic            unused_hi;

    function automatic logic reads_rs1(input logic [4:0] op);
        return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic reads_rs2(input logic [4:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic writes_ws(input logic [4:0] op);
        return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) || (op == OP_LUI) ||
               (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // funct3 011/110/111 are not RV32I loads and so never count as late writers
    function automatic logic is_load(input logic [4:0] op, input logic [2:0] funct3);
        return (op == OP_LOAD) && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction

    // Capture stage: flush injects a bubble, en=0 holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_p1 <= NOP_INST;
        end else if (bus.en) begin
            inst_p1 <= bus.flush ? NOP_INST : bus.inst;
        end
    end

    always_comb begin
        logic [4:0] op;
        logic       valid;
        logic       re1_raw;
        logic       re2_raw;
        logic       wb_raw;
        logic       ws_raw;

        op      = inst_p1[6:2];
        valid   = (inst_p1[1:0] == 2'b11);
        re1_raw = valid && reads_rs1(op);
        re2_raw = valid && reads_rs2(op);
        wb_raw  = valid && writes_ws(op);
        ws_raw  = valid && is_load(op, inst_p1[14:12]);

        bus.rs1 = inst_p1[19:15];
        bus.rs2 = inst_p1[24:20];
        bus.ws  = inst_p1[11:7];
`ifdef RV_X0_FILTER_EN
        bus.re1       = re1_raw && (inst_p1[19:15] != 5'd0);
        bus.re2       = re2_raw && (inst_p1[24:20] != 5'd0);
        bus.we_bypass = wb_raw  && (inst_p1[11:7]  != 5'd0);
        bus.we_stall  = ws_raw  && (inst_p1[11:7]  != 5'd0);
`else
        bus.re1       = re1_raw;
        bus.re2       = re2_raw;
        bus.we_bypass = wb_raw;
        bus.we_stall  = ws_raw;
`endif
    end

    assign unused_hi = &{1'b0, inst_p1[XLEN-1:25]};

endmodule

// File: tb/tb_rv_reg_usage_decode.sv
// Self-checking bench for rv_reg_usage_decode: directed cases plus randomized stream
// against a rule-level reference model.
module tb_rv_reg_usage_decode;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rv_reg_usage_decode_if bus ();

    rv_reg_usage_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rs1, rs2, ws, re1, re2, we_bypass, we_stall}
    logic [18:0] obs;
    assign obs = {bus.rs1, bus.rs2, bus.ws, bus.re1, bus.re2, bus.we_bypass, bus.we_stall};

    logic [31:0] model_reg;

`ifdef RV_X0_FILTER_EN
    localparam logic [18:0] NOP_EXP = {5'd0, 5'd0, 5'd0, 4'b0000};
`else
    localparam logic [18:0] NOP_EXP = {5'd0, 5'd0, 5'd0, 4'b1010};
`endif

    function automatic logic [18:0] model(input logic [31:0] i);
        logic [4:0] op;
        logic [2:0] f3;
        logic       ok;
        logic       r1, r2, wb, st;
        op = i[6:2];
        f3 = i[14:12];
        ok = (i[1:0] == 2'b11);
        r1 = ok && (op inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11001});
        r2 = ok && (op inside {5'b01100, 5'b01000, 5'b11000});
        wb = ok && (op inside {5'b01100, 5'b00100, 5'b00000, 5'b01101, 5'b00101, 5'b11011, 5'b11001});
        st = ok && (op == 5'b00000) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef RV_X0_FILTER_EN
        if (i[19:15] == 5'd0) r1 = 1'b0;
        if (i[24:20] == 5'd0) r2 = 1'b0;
        if (i[11:7] == 5'd0) begin
            wb = 1'b0;
            st = 1'b0;
        end
`endif
        return {i[19:15], i[24:20], i[11:7], r1, r2, wb, st};
    endfunction

    // Apply inputs, take one edge, update the model's held instruction, settle.
    task automatic cycle(input logic e, input logic f, input logic [31:0] i);
        bus.en    = e;
        bus.flush = f;
        bus.inst  = i;
        @(posedge clk);
        if (rst_n && e) model_reg = f ? 32'h0000_0013 : i;
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 32'h002081B3);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== NOP_EXP) begin
            errors++;
            $display("FAIL reset_async got=%h want=%h", obs, NOP_EXP);
        end
        model_reg = 32'h0000_0013;
        cycle(1'b1, 1'b0, 32'h00832283);
        checks++;
        if (obs !== NOP_EXP) begin
            errors++;
            $display("FAIL reset_held got=%h want=%h", obs, NOP_EXP);
        end
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 32'h00832283);
        checks++;
        if (obs !== {5'd6, 5'd8, 5'd5, 4'b1011}) begin
            errors++;
            $display("FAIL reset_first_capture got=%h want=%h", obs, {5'd6, 5'd8, 5'd5, 4'b1011});
        end
    endtask

    task automatic test_directed();
        cycle(1'b1, 1'b0, 32'h002081B3);
        checks++;
        if (obs !== {5'd1, 5'd2, 5'd3, 4'b1110}) begin
            errors++;
            $display("FAIL add got=%h want=%h", obs, {5'd1, 5'd2, 5'd3, 4'b1110});
        end
        cycle(1'b1, 1'b0, 32'h00832283);
        checks++;
        if (obs !== {5'd6, 5'd8, 5'd5, 4'b1011}) begin
            errors++;
            $display("FAIL lw got=%h want=%h", obs, {5'd6, 5'd8, 5'd5, 4'b1011});
        end
        cycle(1'b1, 1'b0, 32'h00742223);
        checks++;
        if (obs !== {5'd8, 5'd7, 5'd4, 4'b1100}) begin
            errors++;
            $display("FAIL sw got=%h want=%h", obs, {5'd8, 5'd7, 5'd4, 4'b1100});
        end
    endtask

    task automatic test_hold_flush();
        cycle(1'b1, 1'b0, 32'h000004B7);
        checks++;
        if (obs !== {5'd0, 5'd0, 5'd9, 4'b0010}) begin
            errors++;
            $display("FAIL lui got=%h want=%h", obs, {5'd0, 5'd0, 5'd9, 4'b0010});
        end
        cycle(1'b0, 1'b0, 32'h00832283);
        checks++;
        if (obs !== {5'd0, 5'd0, 5'd9, 4'b0010}) begin
            errors++;
            $display("FAIL hold got=%h want=%h", obs, {5'd0, 5'd0, 5'd9, 4'b0010});
        end
        cycle(1'b0, 1'b1, 32'h00832283);
        checks++;
        if (obs !== {5'd0, 5'd0, 5'd9, 4'b0010}) begin
            errors++;
            $display("FAIL hold_over_flush got=%h want=%h", obs, {5'd0, 5'd0, 5'd9, 4'b0010});
        end
        cycle(1'b1, 1'b1, 32'h00832283);
        checks++;
        if (obs !== NOP_EXP) begin
            errors++;
            $display("FAIL flush got=%h want=%h", obs, NOP_EXP);
        end
    endtask

    task automatic test_nonwriting();
        cycle(1'b1, 1'b0, 32'h00000073);
        checks++;
        if (obs[3:0] !== 4'b0000) begin
            errors++;
            $display("FAIL ecall got=%b want=0000", obs[3:0]);
        end
        cycle(1'b1, 1'b0, 32'h00000000);
        checks++;
        if (obs[3:0] !== 4'b0000) begin
            errors++;
            $display("FAIL zero_inst got=%b want=0000", obs[3:0]);
        end
        cycle(1'b1, 1'b0, 32'h00000013);
        checks++;
        if (obs !== NOP_EXP) begin
            errors++;
            $display("FAIL addi_x0 got=%h want=%h", obs, NOP_EXP);
        end
        // LUI encoding with a non-32-bit low pair must report nothing
        cycle(1'b1, 1'b0, 32'h000004B5);
        checks++;
        if (obs[3:0] !== 4'b0000) begin
            errors++;
            $display("FAIL low_bits got=%b want=0000", obs[3:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stall_tab;
        logic [31:0] i;
        stall_tab = 8'b0011_0111;
        for (int f = 0; f < 8; f++) begin
            i = {12'h010, 5'd2, f[2:0], 5'd10, 7'b0000011};
            cycle(1'b1, 1'b0, i);
            checks++;
            if (bus.we_stall !== stall_tab[f] || bus.we_bypass !== 1'b1 || bus.ws !== 5'd10) begin
                errors++;
                $display("FAIL load_f3_%0d got stall=%b wb=%b ws=%0d want stall=%b wb=1 ws=10",
                         f, bus.we_stall, bus.we_bypass, bus.ws, stall_tab[f]);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  ops [10];
        logic [31:0] i;
        logic        e, f;
        ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                5'b11001, 5'b01101, 5'b00101, 5'b11011, 5'b11100};
        for (int n = 0; n < 300; n++) begin
            i = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                i[6:2] = ops[$urandom_range(0, 9)];
                i[1:0] = 2'b11;
            end
            if ($urandom_range(0, 5) == 0) i[11:7] = 5'd0;
            if ($urandom_range(0, 5) == 0) i[19:15] = 5'd0;
            e = ($urandom_range(0, 4) != 0);
            f = ($urandom_range(0, 7) == 0);
            cycle(e, f, i);
            checks++;
            if (obs !== model(model_reg)) begin
                errors++;
                $display("FAIL random_%0d inst=%h got=%h want=%h", n, model_reg, obs, model(model_reg));
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        model_reg = 32'h0000_0013;
        bus.en    = 1'b0;
        bus.flush = 1'b0;
        bus.inst  = 32'h0;
        rst_n     = 1'b0;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_hold_flush();
        test_nonwriting();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
